// File: rtl/fft_ofdm_seq.sv
// Symbol sequencer ahead of fft_ofdm: drops the cyclic prefix, frames N_FFT-sample blocks, caps in-flight symbols.
// Defining FFT_OFDM_SEQ_STATUS_EN adds the stat_syms/stat_errs status counters.
module fft_ofdm_seq #(
    parameter int N_FFT   = 128,
    parameter int CP_LEN  = 32,
    parameter int MAX_OUT = 2,
    parameter int DW      = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cfg_inverse,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_sym_start,
    input  logic [DW-1:0] in_real,
    input  logic [DW-1:0] in_imag,
    output logic          fft_sink_valid,
    input  logic          fft_sink_ready,
    output logic          fft_sink_sop,
    output logic          fft_sink_eop,
    output logic [1:0]    fft_sink_error,
    output logic [DW-1:0] fft_sink_real,
    output logic [DW-1:0] fft_sink_imag,
    output logic [7:0]    fft_fftpts_in,
    output logic          fft_inverse,
    input  logic          fft_source_valid,
    input  logic          fft_source_sop,
    input  logic          fft_source_eop,
    input  logic [1:0]    fft_source_error,
    output logic          fft_source_ready,
    input  logic          out_ready,
    output logic          out_sym_done,
    output logic          err_flag,
    input  logic          err_clr
`ifdef FFT_OFDM_SEQ_STATUS_EN
    ,
    output logic [15:0]   stat_syms,
    output logic [7:0]    stat_errs
`endif
);
    localparam int CW = $clog2((N_FFT > CP_LEN) ? N_FFT : CP_LEN) + 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, SKIP, FWD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [OW-1:0] outst_q, outst_d;
    logic          inv_q, inv_d;
    logic          err_q, err_d;
    logic          done_q;
    logic          xfer, marker_err, blk_done, src_eop, err_set;
    logic          unused_src_sop;

    assign unused_src_sop = fft_source_sop;

    // The forward path has no skid buffer, so FFT backpressure reaches upstream directly.
    always_comb begin
        in_ready = 1'b1;
        if (state_q == IDLE)
            in_ready = (outst_q < OW'(MAX_OUT));
        else if (state_q == FWD)
            in_ready = fft_sink_ready;
    end

    assign xfer    = in_valid & in_ready;
    assign src_eop = fft_source_valid & out_ready & fft_source_eop;
    assign err_set = marker_err | (fft_source_valid & out_ready & (|fft_source_error));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        inv_d      = inv_q;
        marker_err = 1'b0;
        blk_done   = 1'b0;
        case (state_q)
            IDLE: begin
                if (xfer && in_sym_start) begin
                    inv_d = cfg_inverse;
                    if (CP_LEN == 1) begin
                        state_d = FWD;
                        cnt_d   = '0;
                    end else begin
                        state_d = SKIP;
                        cnt_d   = CW'(1);
                    end
                end
            end
            SKIP: begin
                if (xfer) begin
                    if (in_sym_start) begin
                        cnt_d      = CW'(1);
                        inv_d      = cfg_inverse;
                        marker_err = 1'b1;
                    end else if (cnt_q == CW'(CP_LEN - 1)) begin
                        state_d = FWD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FWD: begin
                // A marker here cannot truncate the block; it is only flagged.
                if (xfer) begin
                    marker_err = in_sym_start;
                    if (cnt_q == CW'(N_FFT - 1)) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        blk_done = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        if (blk_done && !src_eop && (outst_q < OW'(MAX_OUT)))
            outst_d = outst_q + 1'b1;
        else if (src_eop && !blk_done && (outst_q != '0))
            outst_d = outst_q - 1'b1;
        err_d = err_q;
        if (err_set)
            err_d = 1'b1;
        else if (err_clr)
            err_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            outst_q <= '0;
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            outst_q <= outst_d;
            inv_q   <= inv_d;
            err_q   <= err_d;
            done_q  <= src_eop;
        end
    end

    assign fft_sink_valid   = (state_q == FWD) & in_valid;
    assign fft_sink_sop     = (state_q == FWD) & (cnt_q == '0);
    assign fft_sink_eop     = (state_q == FWD) & (cnt_q == CW'(N_FFT - 1));
    assign fft_sink_error   = 2'b00;
    assign fft_sink_real    = in_real;
    assign fft_sink_imag    = in_imag;
    assign fft_fftpts_in    = 8'(N_FFT);
    assign fft_inverse      = inv_q;
    assign fft_source_ready = out_ready;
    assign out_sym_done     = done_q;
    assign err_flag         = err_q;

`ifdef FFT_OFDM_SEQ_STATUS_EN
    logic [15:0] syms_q;
    logic [7:0]  errs_q;

    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            syms_q <= '0;
            errs_q <= '0;
        end else begin
            if (src_eop)
                syms_q <= syms_q + 1'b1;
            if (err_set)
                errs_q <= errs_q + 1'b1;
        end
    end

    assign stat_syms = syms_q;
    assign stat_errs = errs_q;
`endif
endmodule

// File: tb/tb_fft_ofdm_seq.sv
// Directed bench for fft_ofdm_seq with default parameters (N_FFT=128, CP_LEN=32, MAX_OUT=2).
module tb_fft_ofdm_seq;
    localparam int DW = 18;

    logic          clk = 1'b0;
    logic          reset, cfg_inverse, in_valid, in_ready, in_sym_start;
    logic [DW-1:0] in_real, in_imag, fft_sink_real, fft_sink_imag;
    logic          fft_sink_valid, fft_sink_ready, fft_sink_sop, fft_sink_eop;
    logic [1:0]    fft_sink_error, fft_source_error;
    logic [7:0]    fft_fftpts_in;
    logic          fft_inverse, fft_source_valid, fft_source_sop, fft_source_eop;
    logic          fft_source_ready, out_ready, out_sym_done, err_flag, err_clr;

    int checks = 0;
    int errors = 0;
    int beats, sop_at, eop_at, eop_beat, sop_cnt, eop_cnt, rdy_low, data_bad, inv_bad, fed;

    always #5 clk = ~clk;

    fft_ofdm_seq dut (
        .clk(clk), .reset(reset), .cfg_inverse(cfg_inverse),
        .in_valid(in_valid), .in_ready(in_ready), .in_sym_start(in_sym_start),
        .in_real(in_real), .in_imag(in_imag),
        .fft_sink_valid(fft_sink_valid), .fft_sink_ready(fft_sink_ready),
        .fft_sink_sop(fft_sink_sop), .fft_sink_eop(fft_sink_eop),
        .fft_sink_error(fft_sink_error), .fft_sink_real(fft_sink_real),
        .fft_sink_imag(fft_sink_imag), .fft_fftpts_in(fft_fftpts_in),
        .fft_inverse(fft_inverse), .fft_source_valid(fft_source_valid),
        .fft_source_sop(fft_source_sop), .fft_source_eop(fft_source_eop),
        .fft_source_error(fft_source_error), .fft_source_ready(fft_source_ready),
        .out_ready(out_ready), .out_sym_done(out_sym_done),
        .err_flag(err_flag), .err_clr(err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Offers n samples (sym_start on sample 0 and on inj_idx), records framing seen on accepted beats.
    task automatic feed(input int n, input int inj_idx, input int stall_beat, input int stall_len,
                        input logic inv_cfg, input int tog_idx, input logic exp_inv);
        int i, guard, stall_rem, last_dat;
        beats = 0; sop_at = -1; eop_at = -1; eop_beat = -1; sop_cnt = 0; eop_cnt = 0;
        rdy_low = 0; data_bad = 0; inv_bad = 0; last_dat = -1;
        stall_rem = stall_len; cfg_inverse = inv_cfg; i = 0; guard = 0;
        while (i < n && guard < 2000) begin
            in_valid = 1'b1;
            in_sym_start = (i == 0) || (i == inj_idx);
            in_real = DW'(i + 1);
            in_imag = DW'(5000 + i);
            if (i == tog_idx) cfg_inverse = ~inv_cfg;
            fft_sink_ready = !(beats == stall_beat && stall_rem > 0);
            #1;
            if (!in_ready) rdy_low++;
            if (!fft_sink_ready) stall_rem--;
            if (in_ready) begin
                if (fft_sink_valid) begin
                    beats++;
                    if (fft_sink_real !== in_real || fft_sink_imag !== in_imag) data_bad++;
                    if (last_dat >= 0 && int'(fft_sink_real) != last_dat + 1) data_bad++;
                    last_dat = int'(fft_sink_real);
                    if (fft_inverse !== exp_inv) inv_bad++;
                    if (fft_sink_sop) begin sop_cnt++; sop_at = i; end
                    if (fft_sink_eop) begin eop_cnt++; eop_at = i; eop_beat = beats; end
                end
                i++;
            end
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b0; in_sym_start = 1'b0; fft_sink_ready = 1'b1;
        fed = i;
    endtask

    // One output-side eop beat from the FFT.
    task automatic pop(input logic [1:0] err, input logic clr);
        fft_source_valid = 1'b1; fft_source_eop = 1'b1; fft_source_error = err;
        out_ready = 1'b1; err_clr = clr;
        @(posedge clk); #1;
        fft_source_valid = 1'b0; fft_source_eop = 1'b0; fft_source_error = 2'b00;
        out_ready = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cfg_inverse = 1'b0; in_valid = 1'b1; in_sym_start = 1'b0;
        in_real = '0; in_imag = '0; fft_sink_ready = 1'b1; fft_source_valid = 1'b0;
        fft_source_sop = 1'b0; fft_source_eop = 1'b0; fft_source_error = 2'b00;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_sink_valid", 32'(fft_sink_valid), 0);
        chk("rst_sop", 32'(fft_sink_sop), 0);
        chk("rst_eop", 32'(fft_sink_eop), 0);
        chk("rst_inverse", 32'(fft_inverse), 0);
        chk("rst_err_flag", 32'(err_flag), 0);
        chk("rst_sym_done", 32'(out_sym_done), 0);
        chk("rst_fftpts", 32'(fft_fftpts_in), 128);
        chk("rst_sink_error", 32'(fft_sink_error), 0);
        reset = 1'b0; in_valid = 1'b0;

        // 1: one symbol, 32 CP samples dropped, 128 forwarded
        feed(160, -1, -1, 0, 1'b0, -1, 1'b0);
        chk("t1_fed", fed, 160);
        chk("t1_beats", beats, 128);
        chk("t1_sop_at", sop_at, 32);
        chk("t1_eop_at", eop_at, 159);
        chk("t1_sop_cnt", sop_cnt, 1);
        chk("t1_eop_cnt", eop_cnt, 1);
        chk("t1_data", data_bad, 0);
        chk("t1_rdy_low", rdy_low, 0);
        in_valid = 1'b1; in_real = DW'(7);
        #1;
        chk("t1_idle_discard", 32'(fft_sink_valid), 0);
        chk("t1_idle_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("t1_src_ready", 32'(fft_source_ready), 1);
        pop(2'b00, 1'b0);
        chk("t1_sym_done", 32'(out_sym_done), 1);
        @(posedge clk); #1;
        chk("t1_sym_done_pulse", 32'(out_sym_done), 0);

        // 2: sink backpressure for 5 cycles mid-block
        feed(160, -1, 50, 5, 1'b0, -1, 1'b0);
        chk("t2_rdy_low", rdy_low, 5);
        chk("t2_beats", beats, 128);
        chk("t2_eop_beat", eop_beat, 128);
        chk("t2_data", data_bad, 0);
        pop(2'b00, 1'b0);

        // 3: backlog cap, third symbol held until an output eop
        feed(160, -1, -1, 0, 1'b0, -1, 1'b0);
        chk("t3_a_beats", beats, 128);
        feed(160, -1, -1, 0, 1'b0, -1, 1'b0);
        chk("t3_b_beats", beats, 128);
        rdy_low = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_sym_start = 1'b1; in_real = DW'(1);
            #1;
            if (!in_ready) rdy_low++;
            @(posedge clk); #1;
        end
        chk("t3_held_cycles", rdy_low, 3);
        chk("t3_held_state", 32'(dut.outst_q), 2);
        in_valid = 1'b0; in_sym_start = 1'b0;
        pop(2'b00, 1'b0);
        chk("t3_release_ready", 32'(in_ready), 1);
        chk("t3_release_done", 32'(out_sym_done), 1);
        feed(160, -1, -1, 0, 1'b0, -1, 1'b0);
        chk("t3_c_beats", beats, 128);
        pop(2'b10, 1'b1);
        chk("t3_err_set_wins", 32'(err_flag), 1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t3_err_clr", 32'(err_flag), 0);
        pop(2'b00, 1'b0);
        chk("t3_drained", 32'(dut.outst_q), 0);

        // 4: marker inside FWD at cnt 40
        feed(160, 72, -1, 0, 1'b0, -1, 1'b0);
        chk("t4_err_flag", 32'(err_flag), 1);
        chk("t4_beats", beats, 128);
        chk("t4_sop_cnt", sop_cnt, 1);
        chk("t4_eop_at", eop_at, 159);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("t4_err_clr", 32'(err_flag), 0);
        pop(2'b00, 1'b0);

        // 5: cfg_inverse toggled mid-symbol, relatched at next start
        feed(160, -1, -1, 0, 1'b1, 80, 1'b1);
        chk("t5_inv_stable", inv_bad, 0);
        chk("t5_inv_held", 32'(fft_inverse), 1);
        chk("t5_cfg_now", 32'(cfg_inverse), 0);

        // 6: reset during FWD at cnt 64
        feed(96, -1, -1, 0, 1'b0, -1, 1'b0);
        chk("t6_relatch", inv_bad, 0);
        chk("t6_beats", beats, 64);
        chk("t6_outst_before", 32'(dut.outst_q), 1);
        reset = 1'b1; in_valid = 1'b1; in_real = DW'(97);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("t6_sink_valid", 32'(fft_sink_valid), 0);
        chk("t6_in_ready", 32'(in_ready), 1);
        chk("t6_outst", 32'(dut.outst_q), 0);
        chk("t6_sop", 32'(fft_sink_sop), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
